// File: rtl/verdict_display_sched.sv
// verdict_display_sched: shares a four-digit NOPE/NICE word generator between two
// requesters. Pending requests are arbitrated round-robin. The winner's verdict bit
// is latched, and the generator enable is then driven through BLINKS ON phases
// separated by OFF (blank) phases.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   req0/req1              level requests, held until the matching grant
//   verdict0/verdict1      verdict per requester (0 = NOPE, 1 = NICE), sampled on grant
//   abort                  cancels the job in progress (ignored in idle)
//   grant0/grant1          one-cycle accept pulses
//   word_in, word_enable   drive the word generator's in / enable inputs
//   busy                   high while a job is in ON or OFF
//   active_id              requester owning the current or most recent job
//   done                   one-cycle pulse on normal job completion
module verdict_display_sched #(
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000,
  parameter int unsigned BLINKS     = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic verdict0,
  input  logic req1,
  input  logic verdict1,
  input  logic abort,
  output logic grant0,
  output logic grant1,
  output logic word_in,
  output logic word_enable,
  output logic busy,
  output logic active_id,
  output logic done
);

  localparam int unsigned BlinkW = (BLINKS > 1) ? $clog2(BLINKS) : 1;

  localparam logic [CNT_W-1:0]  OnLast    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OffLast   = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntZero   = '0;
  localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINKS - 1);
  localparam logic [BlinkW-1:0] BlinkZero = '0;
  localparam logic [BlinkW-1:0] BlinkOne  = BlinkW'(1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  // Requester that wins the next tie.
  logic              ptr_q, ptr_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              word_in_q, word_in_d;
  logic              word_enable_q, word_enable_d;
  logic              busy_q, busy_d;
  logic              active_id_q, active_id_d;
  logic              done_q, done_d;

  logic              win;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    blink_d       = blink_q;
    ptr_d         = ptr_q;
    grant0_d      = 1'b0;
    grant1_d      = 1'b0;
    word_in_d     = word_in_q;
    word_enable_d = word_enable_q;
    busy_d        = busy_q;
    active_id_d   = active_id_q;
    done_d        = 1'b0;
    // Tie goes to the pointer; otherwise whichever single request is present.
    win           = (req0 && req1) ? ptr_q : req1;

    unique case (state_q)
      StIdle: begin
        word_enable_d = 1'b0;
        busy_d        = 1'b0;
        phase_d       = CntZero;
        blink_d       = BlinkZero;
        if (req0 || req1) begin
          if (req0 && req1) begin
            ptr_d = ~ptr_q;
          end
          grant0_d      = ~win;
          grant1_d      = win;
          word_in_d     = win ? verdict1 : verdict0;
          active_id_d   = win;
          busy_d        = 1'b1;
          word_enable_d = 1'b1;
          state_d       = StOn;
        end
      end

      StOn: begin
        if (abort) begin
          state_d       = StIdle;
          word_enable_d = 1'b0;
          busy_d        = 1'b0;
          phase_d       = CntZero;
          blink_d       = BlinkZero;
        end else if (phase_q == OnLast) begin
          phase_d       = CntZero;
          word_enable_d = 1'b0;
          if (blink_q == BlinkLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            blink_d = BlinkZero;
          end else begin
            state_d = StOff;
            blink_d = blink_q + BlinkOne;
          end
        end else begin
          phase_d = phase_q + CntOne;
        end
      end

      StOff: begin
        if (abort) begin
          state_d       = StIdle;
          word_enable_d = 1'b0;
          busy_d        = 1'b0;
          phase_d       = CntZero;
          blink_d       = BlinkZero;
        end else if (phase_q == OffLast) begin
          state_d       = StOn;
          word_enable_d = 1'b1;
          phase_d       = CntZero;
        end else begin
          phase_d = phase_q + CntOne;
        end
      end

      default: begin
        state_d       = StIdle;
        word_enable_d = 1'b0;
        busy_d        = 1'b0;
        phase_d       = CntZero;
        blink_d       = BlinkZero;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      phase_q       <= CntZero;
      blink_q       <= BlinkZero;
      ptr_q         <= 1'b0;
      grant0_q      <= 1'b0;
      grant1_q      <= 1'b0;
      word_in_q     <= 1'b0;
      word_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      active_id_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      blink_q       <= blink_d;
      ptr_q         <= ptr_d;
      grant0_q      <= grant0_d;
      grant1_q      <= grant1_d;
      word_in_q     <= word_in_d;
      word_enable_q <= word_enable_d;
      busy_q        <= busy_d;
      active_id_q   <= active_id_d;
      done_q        <= done_d;
    end
  end

  assign grant0      = grant0_q;
  assign grant1      = grant1_q;
  assign word_in     = word_in_q;
  assign word_enable = word_enable_q;
  assign busy        = busy_q;
  assign active_id   = active_id_q;
  assign done        = done_q;

endmodule

// File: tb/tb_verdict_display_sched.sv
// Directed bench for verdict_display_sched with ON_CYCLES=3, OFF_CYCLES=2, BLINKS=2.
// Output vector layout: {grant0, grant1, word_in, word_enable, busy, active_id, done}.
// Stimulus vector layout: {req0, verdict0, req1, verdict1, abort}.
module tb_verdict_display_sched;

  logic clk = 1'b0;
  logic reset;
  logic req0, verdict0, req1, verdict1, abort;
  logic grant0, grant1, word_in, word_enable, busy, active_id, done;

  int n_checks = 0;
  int n_fails  = 0;

  verdict_display_sched #(
    .ON_CYCLES (3),
    .OFF_CYCLES(2),
    .BLINKS    (2),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .verdict0   (verdict0),
    .req1       (req1),
    .verdict1   (verdict1),
    .abort      (abort),
    .grant0     (grant0),
    .grant1     (grant1),
    .word_in    (word_in),
    .word_enable(word_enable),
    .busy       (busy),
    .active_id  (active_id),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] stim;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] outs();
    return {grant0, grant1, word_in, word_enable, busy, active_id, done};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b (g0 g1 win en busy id done)", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] s);
    {req0, verdict0, req1, verdict1, abort} = s;
  endtask

  task automatic add(input logic [4:0] s, input logic [6:0] e);
    vecs.push_back('{stim: s, exp: e});
  endtask

  // One complete job: grant row, 7 rows of blink pattern, then the done row.
  task automatic add_job(input logic [4:0] gin, input logic [4:0] hold, input logic [1:0] g,
                         input logic win, input logic wi);
    logic [6:0] en_pat;
    en_pat = 7'b1100111;
    add(gin, {g, wi, 1'b1, 1'b1, win, 1'b0});
    for (int k = 6; k >= 0; k--) begin
      add(hold, {2'b00, wi, en_pat[k], 1'b1, win, 1'b0});
    end
    add(hold, {2'b00, wi, 1'b0, 1'b0, win, 1'b1});
  endtask

  initial begin
    reset = 1'b1;
    drive(5'b00000);
    #2;
    check("reset_state", outs(), 7'b0000000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Single req0 NOPE job, then idle.
    add_job(5'b10000, 5'b00000, 2'b10, 1'b0, 1'b0);
    add(5'b00000, 7'b0000000);
    // Three ties: 0, 1, 0. Held requests must not be granted mid-job.
    add_job(5'b10110, 5'b10110, 2'b10, 1'b0, 1'b0);
    add_job(5'b10110, 5'b10110, 2'b01, 1'b1, 1'b1);
    add_job(5'b10110, 5'b00000, 2'b10, 1'b0, 1'b0);
    add(5'b00000, 7'b0000000);
    // req1 arrives mid-job of requester 0; granted on the edge after done.
    add_job(5'b10000, 5'b00100, 2'b10, 1'b0, 1'b0);
    add(5'b00100, 7'b0101110);
    add(5'b00000, 7'b0001110);
    add(5'b00000, 7'b0001110);
    add(5'b00000, 7'b0000110);  // first OFF
    add(5'b11001, 7'b0000010);  // abort in OFF, req0 held
    add(5'b11000, 7'b1011100);  // req0 granted next edge
    add(5'b00001, 7'b0010000);  // abort in ON
    // Abort in idle is ignored; singles left the pointer at 1, so the tie goes to req1.
    add(5'b10111, 7'b0111110);
    add(5'b00000, 7'b0011110);
    add(5'b00000, 7'b0011110);
    add(5'b00001, 7'b0010010);  // abort beats ON expiry
    add(5'b00000, 7'b0010010);

    foreach (vecs[i]) begin
      drive(vecs[i].stim);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // verdict0 toggled after grant has no effect on word_in.
    drive(5'b11000);
    @(posedge clk); #1;
    check("toggle_grant", outs(), 7'b1011100);
    req0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      verdict0 = ~verdict0;
      @(posedge clk); #1;
      check($sformatf("toggle_word_in%0d", k), {6'b0, word_in}, 7'b0000001);
    end
    check("toggle_done", {6'b0, done}, 7'b0000001);

    // Reset between edges mid-ON clears outputs immediately and re-arms the pointer.
    drive(5'b10110);
    @(posedge clk); #1;
    check("rst_pre_grant", outs(), 7'b1001100);
    @(posedge clk); #1;
    check("rst_pre_on", outs(), 7'b0001100);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async", outs(), 7'b0000000);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_tie_req0", outs(), 7'b1001100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
